// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm responder block.
package alarm_pkg;

  // Responder states; the RTL keeps the state register as plain logic.
  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_RING   = 2'd1,
    A_SNOOZE = 2'd2
  } alarm_state_t;

  // Default episode lengths, in ticks, and the snooze allowance.
  localparam int RING_MAX_DEF   = 120;
  localparam int SNOOZE_SEC_DEF = 540;
  localparam int MAX_SNOOZE_DEF = 3;

  // Larger of two integers, used to size shared counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Clear-able tick counter with a terminal-count flag against a runtime limit.
// LIMIT is the largest limit that will ever be selected and sizes the counter.
module sec_timer #(
  parameter int LIMIT = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clr,
  input  logic                                       inc,
  input  logic [((LIMIT > 1) ? $clog2(LIMIT) : 1)-1:0] last,
  output logic                                       tc
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count_reg;

  // Count increments, held at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == last);

endmodule

// File: rtl/alarm_responder.sv
// Alarm responder: turns the alarm-match level into beep, snooze, dismiss
// and auto-silence behaviour on the buzzer pin.
import alarm_pkg::*;

module alarm_responder #(
  parameter int RING_MAX   = RING_MAX_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                tick,
  input  logic                                                alarm_on,
  input  logic                                                buzz_req,
  input  logic                                                snooze,
  input  logic                                                dismiss,
  output logic                                                buzzer,
  output logic                                                snoozing,
  output logic [max2($clog2(MAX_SNOOZE+1), 1)-1:0]            snooze_used
);

  // Counter sizing: one timer serves both RING and SNOOZE.
  localparam int CT_MAX = max2(max2(RING_MAX, SNOOZE_SEC), 2);
  localparam int CT_W   = $clog2(CT_MAX);
  localparam int UW     = max2($clog2(MAX_SNOOZE + 1), 1);

  localparam logic [CT_W-1:0] RING_LAST   = CT_W'(RING_MAX - 1);
  localparam logic [CT_W-1:0] SNOOZE_LAST = CT_W'(SNOOZE_SEC - 1);
  localparam logic [UW-1:0]   USED_MAX    = UW'(MAX_SNOOZE);

  // State encodings mirror the package enum.
  localparam logic [1:0] ST_IDLE   = A_IDLE;
  localparam logic [1:0] ST_RING   = A_RING;
  localparam logic [1:0] ST_SNOOZE = A_SNOOZE;

  logic [1:0]      state_reg, state_next;
  logic            phase_reg, phase_next;
  logic [UW-1:0]   used_reg, used_next;
  logic            req_d_reg;
  logic            rise;
  logic            tmr_clr, tmr_inc, tmr_tc;
  logic [CT_W-1:0] tmr_last;

  assign rise     = buzz_req & ~req_d_reg;
  assign tmr_last = (state_reg == ST_SNOOZE) ? SNOOZE_LAST : RING_LAST;

  sec_timer #(
    .LIMIT (CT_MAX)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .last (tmr_last),
    .tc   (tmr_tc)
  );

  // Next-state logic; branch order encodes alarm_on > dismiss > snooze > tick.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    used_next  = used_reg;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    if (!alarm_on) begin
      state_next = ST_IDLE;
      phase_next = 1'b0;
      used_next  = '0;
      tmr_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rise) begin
            state_next = ST_RING;
            phase_next = 1'b1;
            tmr_clr    = 1'b1;
          end
        end
        ST_RING: begin
          if (dismiss) begin
            state_next = ST_IDLE;
            phase_next = 1'b0;
            used_next  = '0;
            tmr_clr    = 1'b1;
          end else if (snooze && (used_reg < USED_MAX)) begin
            state_next = ST_SNOOZE;
            used_next  = used_reg + 1'b1;
            tmr_clr    = 1'b1;
          end else if (tick) begin
            if (tmr_tc) begin
              state_next = ST_IDLE;
              phase_next = 1'b0;
              used_next  = '0;
              tmr_clr    = 1'b1;
            end else begin
              phase_next = ~phase_reg;
              tmr_inc    = 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            state_next = ST_IDLE;
            phase_next = 1'b0;
            used_next  = '0;
            tmr_clr    = 1'b1;
          end else if (tick) begin
            if (tmr_tc) begin
              // Re-ring does not look at buzz_req again.
              state_next = ST_RING;
              phase_next = 1'b1;
              tmr_clr    = 1'b1;
            end else begin
              tmr_inc    = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          phase_next = 1'b0;
          used_next  = '0;
          tmr_clr    = 1'b1;
        end
      endcase
    end
  end

  // State, phase, snooze count and edge-detect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      phase_reg <= 1'b0;
      used_reg  <= '0;
      req_d_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      used_reg  <= used_next;
      req_d_reg <= buzz_req;
    end
  end

  assign buzzer      = (state_reg == ST_RING) & phase_reg;
  assign snoozing    = (state_reg == ST_SNOOZE);
  assign snooze_used = used_reg;

endmodule

// File: tb/tb_alarm_responder.sv
// Directed, table-driven bench for alarm_responder (RING_MAX=4, SNOOZE_SEC=3,
// MAX_SNOOZE=2). Each table row is one event cycle followed by three quiet
// cycles, so tick rows land four clocks apart.
module tb_alarm_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       alarm_on = 1'b1;
  logic       buzz_req = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       buzzer;
  logic       snoozing;
  logic [1:0] snooze_used;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r, o, q, s, d, t;
    logic       b, z;
    logic [1:0] u;
    string      name;
  } vec_t;

  vec_t vecs[$];

  alarm_responder #(
    .RING_MAX   (4),
    .SNOOZE_SEC (3),
    .MAX_SNOOZE (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .alarm_on    (alarm_on),
    .buzz_req    (buzz_req),
    .snooze      (snooze),
    .dismiss     (dismiss),
    .buzzer      (buzzer),
    .snoozing    (snoozing),
    .snooze_used (snooze_used)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, o, q, s, d, t, b, z, input logic [1:0] u,
                     input string n);
    vec_t v;
    v.r = r; v.o = o; v.q = q; v.s = s; v.d = d; v.t = t;
    v.b = b; v.z = z; v.u = u; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic b, input logic z, input logic [1:0] u);
    total++;
    if (buzzer !== b || snoozing !== z || snooze_used !== u) begin
      bad++;
      $display("FAIL %s: got buzzer=%0b snoozing=%0b snooze_used=%0d, want %0b %0b %0d",
               n, buzzer, snoozing, snooze_used, b, z, u);
    end else begin
      $display("ok   %s: buzzer=%0b snoozing=%0b snooze_used=%0d", n, b, z, u);
    end
  endtask

  int high_ct;
  int last_hi;

  initial begin
    //   rst on req snz dis tk | buz szg used
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, "reset");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "rise_ring");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "ring_t1");
    add(0, 1, 1, 0, 0, 1,  1, 0, 0, "ring_t2");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "ring_t3");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "auto_silence");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "no_rering_a");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "no_rering_b");
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, "req_drop");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "ring2");
    add(0, 1, 1, 1, 0, 0,  0, 1, 1, "snooze1");
    add(0, 1, 1, 0, 0, 1,  0, 1, 1, "snz_t1");
    add(0, 1, 1, 0, 0, 1,  0, 1, 1, "snz_t2");
    add(0, 1, 1, 1, 0, 0,  0, 1, 1, "snooze_in_snooze");
    add(0, 1, 0, 0, 0, 1,  1, 0, 1, "re_ring");
    add(0, 1, 0, 1, 0, 0,  0, 1, 2, "snooze2");
    add(0, 1, 0, 0, 0, 1,  0, 1, 2, "snz2_t1");
    add(0, 1, 0, 0, 0, 1,  0, 1, 2, "snz2_t2");
    add(0, 1, 0, 0, 0, 1,  1, 0, 2, "re_ring2");
    add(0, 1, 0, 1, 0, 0,  1, 0, 2, "snooze_limit");
    add(0, 1, 0, 0, 0, 1,  0, 0, 2, "limit_tick");
    add(0, 1, 0, 0, 1, 0,  0, 0, 0, "dismiss");
    add(0, 1, 0, 0, 0, 1,  0, 0, 0, "dismiss_idle");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "ring3");
    add(0, 1, 1, 1, 0, 0,  0, 1, 1, "snooze3");
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, "on_low");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "on_restore");
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, "off_req_low");
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, "off_rise");
    add(0, 1, 1, 0, 0, 0,  0, 0, 0, "on_no_rise");
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, "req_low2");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "ring4");
    add(0, 1, 1, 1, 1, 0,  0, 0, 0, "snz_dis_same");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "snz_dis_idle");
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, "req_low3");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "ring5");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "r5_t1");
    add(0, 1, 1, 0, 0, 1,  1, 0, 0, "r5_t2");
    add(0, 1, 1, 0, 0, 1,  0, 0, 0, "r5_t3");
    add(0, 1, 1, 1, 0, 1,  0, 1, 1, "snooze_on_terminal");
    add(0, 1, 1, 0, 1, 0,  0, 0, 0, "dismiss_snz");
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, "req_low4");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "ring6");
    add(1, 1, 1, 0, 0, 0,  0, 0, 0, "rst_mid_ring");
    add(0, 1, 1, 0, 0, 0,  1, 0, 0, "ring_after_rst");
    add(0, 1, 1, 1, 0, 0,  0, 1, 1, "snooze6");
    add(1, 1, 1, 0, 0, 0,  0, 0, 0, "rst_mid_snooze");
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, "post_rst");

    // Settle in reset before the table starts.
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst      = vecs[i].r;
      alarm_on = vecs[i].o;
      buzz_req = vecs[i].q;
      snooze   = vecs[i].s;
      dismiss  = vecs[i].d;
      tick     = vecs[i].t;
      @(posedge clk);
      #1;
      chk(vecs[i].name, vecs[i].b, vecs[i].z, vecs[i].u);
      snooze  = 1'b0;
      dismiss = 1'b0;
      tick    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({vecs[i].name, "_hold"}, vecs[i].b, vecs[i].z, vecs[i].u);
    end

    // Free-running tick every 4 clocks across a whole ring episode:
    // buzzer high for 3 + 4 cycles, last high sample at cycle 11.
    buzz_req = 1'b1;
    @(posedge clk);
    #1;
    chk("hand_entry", 1'b1, 1'b0, 2'd0);
    high_ct = 0;
    last_hi = 0;
    for (int c = 1; c <= 20; c++) begin
      tick = ((c % 4) == 0);
      @(posedge clk);
      #1;
      tick = 1'b0;
      if (buzzer === 1'b1) begin
        high_ct++;
        last_hi = c;
      end
    end
    total++;
    if (high_ct != 7) begin
      bad++;
      $display("FAIL hand_high_count: got %0d, want 7", high_ct);
    end else begin
      $display("ok   hand_high_count: %0d", high_ct);
    end
    total++;
    if (last_hi != 11) begin
      bad++;
      $display("FAIL hand_last_high: got %0d, want 11", last_hi);
    end else begin
      $display("ok   hand_last_high: %0d", last_hi);
    end
    chk("hand_end_idle", 1'b0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_responder.md
# alarm_responder

Alarm responder that consumes the raw alarm-match request from the clock datapath and turns it into user-facing buzzer behaviour: beep pattern, snooze, dismiss, auto-silence. It is the consumer end of the alarm interface. It sits between the alarm-match comparator output, gated by the Alarmon switch, and the physical buzzer pin. Internal time is counted in 1 Hz `tick` enables on a single system clock.

## Interface

Parameters:
- `RING_MAX`, default 120: ticks a ring episode lasts before auto-silence.
- `SNOOZE_SEC`, default 540: ticks spent in snooze before re-ringing.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm episode.

Ports:
- `clk`  in  1: system clock. One clock only.
- `rst`  in  1: reset, synchronous, active-high.
- `tick`  in  1: one-`clk`-wide enable, nominally 1/sec.
- `alarm_on`  in  1: alarm master enable (Alarmon switch level).
- `buzz_req`  in  1: alarm-match level from the comparator. High for the whole matching minute.
- `snooze`  in  1: snooze button, debounced upstream, one-`clk` pulse.
- `dismiss`  in  1: dismiss button, debounced upstream, one-`clk` pulse.
- `buzzer`  out  1: buzzer drive.
- `snoozing`  out  1: high while in SNOOZE.
- `snooze_used`  out  $clog2(MAX_SNOOZE+1): snoozes consumed in the current episode.

## Operation

- States: IDLE, RING, SNOOZE.
- Rising-edge detect on `buzz_req`:
  - `req_d` is registered and resets to 0.
  - `rise = buzz_req & ~req_d`.
  - If `buzz_req` is already high when reset releases, this counts as a rise.
- IDLE → RING on `rise & alarm_on`. On entry: `sec_ct` ← 0, `phase` ← 1.
- RING:
  - Each tick: `phase` toggles and `sec_ct` increments. This gives a 1 s on / 1 s off beep.
  - Tick with `sec_ct == RING_MAX-1` → IDLE (auto-silence).
  - `snooze` with `snooze_used < MAX_SNOOZE` → SNOOZE. On this transition: `snooze_used` increments, `sec_ct` ← 0.
  - `snooze` with the limit reached is ignored.
- SNOOZE:
  - Each tick: `sec_ct` increments.
  - Tick with `sec_ct == SNOOZE_SEC-1` → RING. Re-entry is unconditional: `buzz_req` is not rechecked. `sec_ct` ← 0, `phase` ← 1.
- `dismiss` in RING or SNOOZE → IDLE.
- Every transition to IDLE clears `snooze_used`.
- Once in IDLE, only a new rising edge restarts the alarm. A dismissed alarm does not re-ring within the same matching minute.
- `alarm_on` low forces IDLE from any state and clears `snooze_used`. `rise` is ignored while `alarm_on` is low.
- Priority on the same cycle, highest first: `rst` > `~alarm_on` > `dismiss` > `snooze` > tick-driven transition.
  - A tick coinciding with `snooze` in RING does not also toggle `phase`.
- Output decode:
  - `buzzer = (state==RING) & phase`.
  - `snoozing = (state==SNOOZE)`.
  - All outputs decode from registers only. There is no input-to-output combinational path.
- `snooze`/`dismiss` in IDLE are ignored.
- A `snooze` in SNOOZE does not restart the timer.

## Timing

- Reset values:
  - state IDLE
  - `sec_ct` 0
  - `phase` 0
  - `snooze_used` 0
  - `req_d` 0
  - Hence `buzzer` = 0, `snoozing` = 0.
- Response latency:
  - `buzz_req` high at edge k with `req_d` = 0 → `buzzer` = 1 after edge k (one cycle).
  - Button pulse at edge k → state change visible after edge k.
- RING episode: exactly `RING_MAX` ticks, counting from the first tick after entry.
- SNOOZE: exactly `SNOOZE_SEC` ticks.
- Reset mid-RING or mid-SNOOZE returns to the reset values at the next edge.
- Counter width: `sec_ct` is sized $clog2(max(RING_MAX,SNOOZE_SEC)). Compares are against parameter-minus-one. It never wraps past the terminal value.

## Structure

- Shared package `alarm_pkg`:
  - `typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_state_t`.
  - Default constants for `RING_MAX`, `SNOOZE_SEC`, `MAX_SNOOZE`.
- One sub-module, `sec_timer`:
  - Clear-able tick counter with a terminal-count flag at parameter `LIMIT`.
  - A single instance is shared by RING and SNOOZE, since the states are exclusive. The limit is selected by state.
- Remaining RTL in `alarm_responder`:
  - FSM
  - edge detector
  - phase toggle
  - snooze counter

## Test plan

Bench parameters: `RING_MAX`=4, `SNOOZE_SEC`=3, `MAX_SNOOZE`=2, tick every 4 clk.

- **Ring, beep, auto-silence:** `buzz_req` 0→1 with `alarm_on`=1 → next cycle `buzzer`=1. Thereafter `buzzer` toggles on each tick: 1,0,1,0. The 4th tick returns to IDLE with `buzzer`=0. `buzz_req` held high causes no re-ring.
- **Snooze cycle:** ring, then `snooze` → `snoozing`=1, `snooze_used`=1, `buzzer`=0. After 3 ticks, RING resumes with `buzzer`=1 even though `buzz_req`=0.
- **Snooze limit:** snooze twice (`snooze_used`=2). A third `snooze` during RING is ignored and the state stays RING. `dismiss` → IDLE, `snooze_used`=0.
- **alarm_on gating:** `alarm_on`=0 during SNOOZE → IDLE next cycle, `snoozing`=0. `buzz_req` rising while `alarm_on`=0 → stays IDLE.
- **Simultaneous events:** `dismiss` and `snooze` on the same cycle in RING → IDLE. `snooze` on the terminal tick → SNOOZE, not IDLE.
- **Reset:** `rst` asserted mid-RING → all outputs 0 next edge. `buzz_req` high through reset release → RING one cycle after `rst` deasserts.
